// File: rtl/fifo_srl_flow_if.sv
// ---------------------------------------------------------------------------
// fifo_srl_flow_if
//   Stream handshake bundle between a producer/consumer pair and the
//   fifo_srl_flow buffer.
//
//   Signals:
//     if_write   producer push request
//     if_din     push data (DATA_WIDTH bits)
//     if_full_n  1 = space available, push accepted only when 1
//     if_read    consumer pop request
//     if_dout    head-of-queue data, show-ahead
//     if_empty_n 1 = if_dout valid, pop accepted only when 1
//
//   Modports:
//     slave  - the FIFO side (takes requests, drives status and data)
//     master - the kernel side (drives requests, observes status and data)
// ---------------------------------------------------------------------------
interface fifo_srl_flow_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;

    modport slave (
        input  if_write,
        input  if_din,
        input  if_read,
        output if_full_n,
        output if_dout,
        output if_empty_n
    );

    modport master (
        output if_write,
        output if_din,
        output if_read,
        input  if_full_n,
        input  if_dout,
        input  if_empty_n
    );
endinterface

// File: rtl/fifo_srl_flow.sv
// ---------------------------------------------------------------------------
// fifo_srl_flow
//   Show-ahead FIFO on shift-register storage for inter-kernel streams.
//   Every accepted push shifts the whole store up one entry and inserts the
//   new word at entry 0; the oldest word therefore lives at entry count-1,
//   which is where the read mux points.
//
//   Ports:
//     clk          rising-edge clock
//     reset_n      asynchronous active-low reset (control state only)
//     fifo         handshake bundle, slave side (see fifo_srl_flow_if)
//     count        occupancy 0..DEPTH
//     almost_full  count >= DEPTH-AFULL_TH
//     almost_empty count <= AEMPTY_TH
//     overflow     sticky: push attempted while full
//     underflow    sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module fifo_srl_flow #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 1,
    parameter int CNT_WIDTH  = 2,
    parameter int AFULL_TH   = 1,
    parameter int AEMPTY_TH  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fifo_srl_flow_if.slave       fifo,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_LVL  = CNT_WIDTH'(DEPTH - AFULL_TH);
    localparam logic [CNT_WIDTH-1:0] AE_LVL  = CNT_WIDTH'(AEMPTY_TH);

    // Storage is deliberately left out of reset so it maps onto SRL primitives.
    logic [DATA_WIDTH-1:0] srl_q [DEPTH];

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  push;
    logic                  pop;
    logic [CNT_WIDTH-1:0]  cnt_m1;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Requests are qualified by the registered status, so a write while full
    // is dropped even when a pop frees a slot in the same cycle.
    assign push = fifo.if_write & full_n_q;
    assign pop  = fifo.if_read  & empty_n_q;

    // -----------------------------------------------------------------------
    // Shift-register storage
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_srl
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (push) begin
                        srl_q[gi] <= fifo.if_din;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (push) begin
                        srl_q[gi] <= srl_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Oldest entry sits at count-1; when empty the address parks at 0.
    always_comb begin
        cnt_m1  = count_q - CNT_WIDTH'(1);
        rd_addr = '0;
        if (count_q != '0) begin
            rd_addr = cnt_m1[ADDR_WIDTH-1:0];
        end
    end

    assign fifo.if_dout = srl_q[rd_addr];

    // -----------------------------------------------------------------------
    // Occupancy and flags. Flags are derived from the next count so they
    // change on the same edge as count itself.
    // -----------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != DEPTH_C);
        afull_d   = (count_d >= AF_LVL);
        aempty_d  = (count_d <= AE_LVL);

        ovf_d = ovf_q | (fifo.if_write & ~full_n_q);
        unf_d = unf_q | (fifo.if_read  & ~empty_n_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign count           = count_q;
    assign fifo.if_empty_n = empty_n_q;
    assign fifo.if_full_n  = full_n_q;
    assign almost_full     = afull_q;
    assign almost_empty    = aempty_q;
    assign overflow        = ovf_q;
    assign underflow       = unf_q;

endmodule

// File: tb/tb_fifo_srl_flow.sv
// ---------------------------------------------------------------------------
// tb_fifo_srl_flow
//   Drives two instances in lock-step: an 8-bit, 4-deep build used for the
//   directed scenarios, and the default 256-bit, 2-deep build. Each instance
//   is compared every cycle against a queue-based reference.
// ---------------------------------------------------------------------------
module tb_fifo_srl_flow;

    localparam int D8 = 4;
    localparam int D2 = 2;

    logic clk;
    logic reset_n;

    fifo_srl_flow_if #(.DATA_WIDTH(8)) bus8 ();
    fifo_srl_flow_if                   bus256 ();

    logic [2:0] cnt8;
    logic       af8, ae8, ovf8_o, unf8_o;
    logic [1:0] cnt2;
    logic       af2, ae2, ovf2_o, unf2_o;

    fifo_srl_flow #(
        .DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .CNT_WIDTH(3),
        .AFULL_TH(1), .AEMPTY_TH(1)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .fifo(bus8.slave),
        .count(cnt8), .almost_full(af8), .almost_empty(ae8),
        .overflow(ovf8_o), .underflow(unf8_o)
    );

    fifo_srl_flow dut2 (
        .clk(clk), .reset_n(reset_n), .fifo(bus256.slave),
        .count(cnt2), .almost_full(af2), .almost_empty(ae2),
        .overflow(ovf2_o), .underflow(unf2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [7:0]   q8 [$];
    logic [255:0] q2 [$];
    bit           m_ovf8, m_unf8, m_ovf2, m_unf2;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_models();
        int n8, n2;
        n8 = q8.size();
        n2 = q2.size();
        chk("count8",   256'(cnt8),             256'(n8));
        chk("empty_n8", 256'(bus8.if_empty_n),  256'(n8 != 0));
        chk("full_n8",  256'(bus8.if_full_n),   256'(n8 != D8));
        chk("afull8",   256'(af8),              256'(n8 >= D8 - 1));
        chk("aempty8",  256'(ae8),              256'(n8 <= 1));
        chk("ovf8",     256'(ovf8_o),           256'(m_ovf8));
        chk("unf8",     256'(unf8_o),           256'(m_unf8));
        if (n8 != 0) chk("dout8", 256'(bus8.if_dout), 256'(q8[0]));
        chk("count2",   256'(cnt2),             256'(n2));
        chk("empty_n2", 256'(bus256.if_empty_n), 256'(n2 != 0));
        chk("full_n2",  256'(bus256.if_full_n),  256'(n2 != D2));
        chk("afull2",   256'(af2),              256'(n2 >= D2 - 1));
        chk("aempty2",  256'(ae2),              256'(n2 <= 1));
        chk("ovf2",     256'(ovf2_o),           256'(m_ovf2));
        chk("unf2",     256'(unf2_o),           256'(m_unf2));
        if (n2 != 0) chk("dout2", bus256.if_dout, q2[0]);
    endtask

    // One clock of traffic: inputs change on the falling edge, the reference
    // is advanced at the rising edge, outputs are checked 1 time unit later.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit verbose);
        logic [255:0] d2;
        bit pu, po;
        d2 = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        bus8.if_write   = w;
        bus8.if_din     = d;
        bus8.if_read    = r;
        bus256.if_write = w;
        bus256.if_din   = d2;
        bus256.if_read  = r;
        @(posedge clk);
        pu = w && (q8.size() < D8);
        po = r && (q8.size() > 0);
        if (w && !pu) m_ovf8 = 1'b1;
        if (r && !po) m_unf8 = 1'b1;
        if (po) void'(q8.pop_front());
        if (pu) q8.push_back(d);
        pu = w && (q2.size() < D2);
        po = r && (q2.size() > 0);
        if (w && !pu) m_ovf2 = 1'b1;
        if (r && !po) m_unf2 = 1'b1;
        if (po) void'(q2.pop_front());
        if (pu) q2.push_back(d2);
        #1;
        check_models();
        if (verbose)
            $display("step wr=%0b din=%02h rd=%0b -> count=%0d dout=%02h full_n=%0b empty_n=%0b af=%0b ae=%0b ovf=%0b unf=%0b",
                     w, d, r, cnt8, bus8.if_dout, bus8.if_full_n, bus8.if_empty_n,
                     af8, ae8, ovf8_o, unf8_o);
    endtask

    task automatic model_reset();
        q8.delete();
        q2.delete();
        m_ovf8 = 1'b0; m_unf8 = 1'b0;
        m_ovf2 = 1'b0; m_unf2 = 1'b0;
    endtask

    task automatic idle_inputs();
        bus8.if_write   = 1'b0;
        bus8.if_read    = 1'b0;
        bus8.if_din     = '0;
        bus256.if_write = 1'b0;
        bus256.if_read  = 1'b0;
        bus256.if_din   = '0;
    endtask

    initial begin
        int wp;
        idle_inputs();
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",   256'(cnt8), 256'(0));
        chk("rst_empty_n", 256'(bus8.if_empty_n), 256'(0));
        chk("rst_full_n",  256'(bus8.if_full_n),  256'(1));
        chk("rst_aempty",  256'(ae8), 256'(1));
        chk("rst_afull",   256'(af8), 256'(0));
        chk("rst_ovf",     256'(ovf8_o), 256'(0));
        chk("rst_unf",     256'(unf8_o), 256'(0));
        check_models();
        @(negedge clk);
        reset_n = 1'b1;

        // Fill 0x11..0x44
        step(1'b1, 8'h11, 1'b0, 1'b1);
        chk("fill1_count", 256'(cnt8), 256'(1));
        chk("fill1_dout",  256'(bus8.if_dout), 256'(8'h11));
        step(1'b1, 8'h22, 1'b0, 1'b1);
        chk("fill2_count", 256'(cnt8), 256'(2));
        chk("fill2_afull", 256'(af8), 256'(0));
        step(1'b1, 8'h33, 1'b0, 1'b1);
        chk("fill3_count", 256'(cnt8), 256'(3));
        chk("fill3_afull", 256'(af8), 256'(1));
        chk("fill3_full_n", 256'(bus8.if_full_n), 256'(1));
        step(1'b1, 8'h44, 1'b0, 1'b1);
        chk("fill4_count", 256'(cnt8), 256'(4));
        chk("fill4_full_n", 256'(bus8.if_full_n), 256'(0));
        chk("fill4_dout",  256'(bus8.if_dout), 256'(8'h11));

        // Push while full is dropped
        step(1'b1, 8'h55, 1'b0, 1'b1);
        chk("ovf_set",   256'(ovf8_o), 256'(1));
        chk("ovf_count", 256'(cnt8), 256'(4));

        // Drain in order
        chk("pop1_data", 256'(bus8.if_dout), 256'(8'h11));
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("pop2_data", 256'(bus8.if_dout), 256'(8'h22));
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("pop3_data", 256'(bus8.if_dout), 256'(8'h33));
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("pop4_data", 256'(bus8.if_dout), 256'(8'h44));
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("drained_empty_n", 256'(bus8.if_empty_n), 256'(0));

        // Pop while empty
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("unf_set",    256'(unf8_o), 256'(1));
        chk("unf_count",  256'(cnt8), 256'(0));
        chk("unf_aempty", 256'(ae8), 256'(1));

        // Push + pop on empty: push taken, no bypass
        step(1'b1, 8'hA5, 1'b1, 1'b1);
        chk("pp_empty_count", 256'(cnt8), 256'(1));
        chk("pp_empty_dout",  256'(bus8.if_dout), 256'(8'hA5));
        chk("pp_empty_unf",   256'(unf8_o), 256'(1));

        // Build 0x01,0x02 then push/pop 0x03 three times
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'h02, 1'b0, 1'b1);
        chk("pp_pre_dout", 256'(bus8.if_dout), 256'(8'h01));
        step(1'b1, 8'h03, 1'b1, 1'b1);
        chk("pp1_count", 256'(cnt8), 256'(2));
        chk("pp1_dout",  256'(bus8.if_dout), 256'(8'h02));
        step(1'b1, 8'h03, 1'b1, 1'b1);
        chk("pp2_count", 256'(cnt8), 256'(2));
        chk("pp2_dout",  256'(bus8.if_dout), 256'(8'h03));
        step(1'b1, 8'h03, 1'b1, 1'b1);
        chk("pp3_count", 256'(cnt8), 256'(2));

        // Reach 3 then reset between edges
        step(1'b1, 8'h04, 1'b0, 1'b1);
        chk("pre_rst_count", 256'(cnt8), 256'(3));
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_count",   256'(cnt8), 256'(0));
        chk("mid_rst_empty_n", 256'(bus8.if_empty_n), 256'(0));
        chk("mid_rst_full_n",  256'(bus8.if_full_n), 256'(1));
        chk("mid_rst_ovf",     256'(ovf8_o), 256'(0));
        chk("mid_rst_unf",     256'(unf8_o), 256'(0));
        check_models();
        $display("reset pulse mid-cycle -> count=%0d", cnt8);
        reset_n = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b1);
        chk("post_rst_dout",  256'(bus8.if_dout), 256'(8'h77));
        chk("post_rst_count", 256'(cnt8), 256'(1));

        // Randomised traffic, bias alternates to visit full and empty
        for (int i = 0; i < 10000; i++) begin
            wp = ((i / 500) % 2 == 1) ? 75 : 30;
            step($urandom_range(0, 99) < wp, 8'($urandom()),
                 $urandom_range(0, 99) < (100 - wp), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
